// File: rtl/sram_player.sv
// sram_player: plays a sample range out of SRAM at a fixed-point rate.
// Runs on i_clk and fetches one output sample per i_sample_tick, forward or reverse, with optional looping.
// Build option: define SRAM_PLAYER_INTERP_EN to fetch the neighbour sample and interpolate linearly.
// Without it, the player holds sample A (sample-and-hold).
//
// state | meaning
// IDLE  | block disabled, position cleared
// STOP  | position parked at the range start (fwd) or range end (rev)
// PLAY  | ticks trigger fetches and the position advances
// PAUSE | position held, ticks ignored
module sram_player #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int SPD_W    = 3,
    parameter int FRAC_W   = 4,
    parameter int SRAM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_sample_tick,
    input  logic              i_play_pause,
    input  logic              i_stop,
    input  logic              i_speed_up,
    input  logic              i_speed_down,
    input  logic              i_reverse,
    input  logic              i_loop,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic [DATA_W-1:0] i_sram_dq,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_dacdat,
    output logic              o_valid,
    output logic              o_play_n,
    output logic [2:0]        o_state,
    output logic [SPD_W:0]    o_speed,
    output logic              o_dir,
    output logic              o_done,
    output logic              o_overrun
);
    localparam int PW     = ADDR_W + FRAC_W;
    localparam int MAXSPD = 2**SPD_W - 1;
    localparam logic signed [SPD_W:0] SPD_MAX = MAXSPD[SPD_W:0];
    localparam logic signed [SPD_W:0] SPD_MIN = -SPD_MAX;
    localparam logic signed [SPD_W:0] SPD_ONE = {{SPD_W{1'b0}}, 1'b1};
    localparam logic [2:0]            LAT_M1  = 3'(SRAM_LAT - 1);
    localparam logic [FRAC_W-1:0]     FRAC0   = '0;

    typedef enum logic [2:0] {IDLE = 3'b001, STOP = 3'b011, PLAY = 3'b100, PAUSE = 3'b101} state_t;
    typedef enum logic [2:0] {F_IDLE, F_A, F_B, F_CALC, F_OUT} fseq_t;

    state_t              state_q, state_d;
    fseq_t               fseq_q;
    logic [2:0]          cnt_q;
    logic signed [SPD_W:0] speed_q;
    logic                dir_q, dir_d, fdir_q;
    logic [PW-1:0]       pos_q, step_q, adv_pos;
    logic [ADDR_W-1:0]   rng_start_q, rng_end_q, sram_addr_q;
    logic [DATA_W-1:0]   a_q, res_q, dacdat_q;
    logic                valid_q, done_q, play_n_q, overrun_q;
    logic                ctrl_ok, fire, past;
`ifdef SRAM_PLAYER_INTERP_EN
    logic [DATA_W-1:0]   b_q;
    logic [ADDR_W-1:0]   nb_addr;
`endif

    // Step size is a constant table indexed by level; slow rates divide one sample into 1-L parts.
    function automatic logic [PW-1:0] step_of(input logic signed [SPD_W:0] lvl);
        logic [PW-1:0] s;
        s = '0;
        if (!lvl[SPD_W]) begin
            s = PW'((int'(lvl) + 1) << FRAC_W);
        end else begin
            for (int k = 1; k <= MAXSPD; k++) begin
                if (int'(lvl) == -k) s = PW'(((2**FRAC_W) / (k + 1) > 0) ? (2**FRAC_W) / (k + 1) : 1);
            end
        end
        return s;
    endfunction

`ifdef SRAM_PLAYER_INTERP_EN
    // out = A + floor((B-A)*frac / 2**FRAC_W); always lands between A and B.
    function automatic logic [DATA_W-1:0] interp(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                 input logic [FRAC_W-1:0] f);
        logic signed [DATA_W:0]          d;
        logic signed [DATA_W+FRAC_W+1:0] de, fe, ae, p, s;
        d  = $signed({b[DATA_W-1], b}) - $signed({a[DATA_W-1], a});
        de = {{(FRAC_W+1){d[DATA_W]}}, d};
        fe = {{(DATA_W+2){1'b0}}, f};
        ae = {{(FRAC_W+2){a[DATA_W-1]}}, a};
        p  = de * fe;
        s  = ae + (p >>> FRAC_W);
        return s[DATA_W-1:0];
    endfunction

    // Neighbour for interpolation, clamped so it never leaves the latched range.
    always_comb begin
        nb_addr = sram_addr_q;
        if (fdir_q) begin
            if (sram_addr_q > rng_start_q) nb_addr = sram_addr_q - 1'b1;
        end else begin
            if (sram_addr_q < rng_end_q) nb_addr = sram_addr_q + 1'b1;
        end
    end
`endif

    // Next position and range-end detection; one extra bit catches address overflow and underflow.
    always_comb begin
        logic [PW:0] pos_ext, step_ext, sum, diff;
        logic        over, under;
        pos_ext  = {1'b0, pos_q};
        step_ext = {1'b0, step_q};
        sum      = pos_ext + step_ext;
        diff     = pos_ext - step_ext;
        over     = sum[PW:FRAC_W] > {1'b0, rng_end_q};
        under    = diff[PW] || (diff[PW-1:FRAC_W] < rng_start_q);
        past     = fdir_q ? under : over;
        adv_pos  = fdir_q ? diff[PW-1:0] : sum[PW-1:0];
    end

    assign ctrl_ok = i_enable && !i_stop && !i_play_pause;
    assign fire    = (state_q == PLAY) && (fseq_q == F_OUT) && ctrl_ok;
    assign dir_d   = (state_q != IDLE && i_enable && i_reverse) ? !dir_q : dir_q;

    // Transport next state: disable beats everything, stop beats play/pause.
    always_comb begin
        state_d = state_q;
        if (!i_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = STOP;
                STOP:    if (i_play_pause && !i_stop) state_d = PLAY;
                PLAY:    if (i_stop) state_d = STOP;
                         else if (i_play_pause) state_d = PAUSE;
                         else if (fire && past && !i_loop) state_d = STOP;
                PAUSE:   if (i_stop) state_d = STOP;
                         else if (i_play_pause) state_d = PLAY;
                default: state_d = IDLE;
            endcase
        end
    end

    // Transport state, speed, position and the fetch sequencer with its registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            fseq_q      <= F_IDLE;
            cnt_q       <= '0;
            speed_q     <= '0;
            dir_q       <= 1'b0;
            fdir_q      <= 1'b0;
            pos_q       <= '0;
            step_q      <= '0;
            rng_start_q <= '0;
            rng_end_q   <= '0;
            sram_addr_q <= '0;
            a_q         <= '0;
            res_q       <= '0;
            dacdat_q    <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            play_n_q    <= 1'b1;
            overrun_q   <= 1'b0;
`ifdef SRAM_PLAYER_INTERP_EN
            b_q         <= '0;
`endif
        end else begin
            state_q  <= state_d;
            play_n_q <= (state_d != PLAY);
            dir_q    <= dir_d;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;

            if (state_q == IDLE) begin
                if (state_d == STOP) speed_q <= '0;
            end else if (i_enable) begin
                if (i_speed_up && !i_speed_down && speed_q != SPD_MAX) speed_q <= speed_q + SPD_ONE;
                else if (i_speed_down && !i_speed_up && speed_q != SPD_MIN) speed_q <= speed_q - SPD_ONE;
            end

            case (state_q)
                IDLE: pos_q <= '0;
                STOP: begin
                    pos_q       <= dir_d ? {i_end_addr, FRAC0} : {i_start_addr, FRAC0};
                    rng_start_q <= i_start_addr;
                    rng_end_q   <= i_end_addr;
                end
                PLAY: if (fire) pos_q <= past ? (fdir_q ? {rng_end_q, FRAC0} : {rng_start_q, FRAC0}) : adv_pos;
                default: ;
            endcase

            if (fire) begin
                dacdat_q <= res_q;
                valid_q  <= 1'b1;
                done_q   <= past && !i_loop;
            end

            if (state_d == STOP || state_d == IDLE) overrun_q <= 1'b0;
            else if (state_q == PLAY && i_sample_tick && fseq_q != F_IDLE) overrun_q <= 1'b1;

            if (state_q != PLAY || !ctrl_ok) begin
                fseq_q <= F_IDLE;
            end else begin
                case (fseq_q)
                    F_IDLE: if (i_sample_tick) begin
                        fseq_q      <= F_A;
                        cnt_q       <= LAT_M1;
                        sram_addr_q <= pos_q[PW-1:FRAC_W];
                        step_q      <= step_of(speed_q);
                        fdir_q      <= dir_d;
                    end
                    F_A: if (cnt_q == 3'd0) begin
                        a_q <= i_sram_dq;
`ifdef SRAM_PLAYER_INTERP_EN
                        fseq_q      <= F_B;
                        cnt_q       <= LAT_M1;
                        sram_addr_q <= nb_addr;
`else
                        fseq_q      <= F_CALC;
`endif
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
`ifdef SRAM_PLAYER_INTERP_EN
                    F_B: if (cnt_q == 3'd0) begin
                        b_q    <= i_sram_dq;
                        fseq_q <= F_CALC;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                    F_CALC: begin
                        res_q  <= interp(a_q, b_q, pos_q[FRAC_W-1:0]);
                        fseq_q <= F_OUT;
                    end
`else
                    F_CALC: begin
                        res_q  <= a_q;
                        fseq_q <= F_OUT;
                    end
`endif
                    default: fseq_q <= F_IDLE;
                endcase
            end
        end
    end

    assign o_sram_addr = sram_addr_q;
    assign o_dacdat    = dacdat_q;
    assign o_valid     = valid_q;
    assign o_play_n    = play_n_q;
    assign o_state     = state_q;
    assign o_speed     = speed_q;
    assign o_dir       = dir_q;
    assign o_done      = done_q;
    assign o_overrun   = overrun_q;
endmodule

// File: tb/tb_sram_player.sv
// Bench for sram_player: a two-cycle SRAM model plus a position-arithmetic playback model.
`timescale 1ns/1ps
module tb_sram_player;
    localparam int AW = 8, DW = 16, SW = 3, FW = 4, LAT = 2, FR = 16;
`ifdef SRAM_PLAYER_INTERP_EN
    localparam int EXP_LAT = 2*LAT + 2;
`else
    localparam int EXP_LAT = LAT + 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0, enable = 1'b0, tick = 1'b0, pp = 1'b0, stp = 1'b0;
    logic up = 1'b0, dn = 1'b0, rev = 1'b0, loop_l = 1'b0;
    logic [AW-1:0] start_a = '0, end_a = '0;
    logic [DW-1:0] dq;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] dacdat;
    logic valid, play_n, dir, done, overrun;
    logic [2:0] state;
    logic [SW:0] speed;

    sram_player #(.ADDR_W(AW), .DATA_W(DW), .SPD_W(SW), .FRAC_W(FW), .SRAM_LAT(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_sample_tick(tick),
        .i_play_pause(pp), .i_stop(stp), .i_speed_up(up), .i_speed_down(dn),
        .i_reverse(rev), .i_loop(loop_l), .i_start_addr(start_a), .i_end_addr(end_a),
        .i_sram_dq(dq), .o_sram_addr(sram_addr), .o_dacdat(dacdat), .o_valid(valid),
        .o_play_n(play_n), .o_state(state), .o_speed(speed), .o_dir(dir),
        .o_done(done), .o_overrun(overrun));

    always #5 clk = ~clk;

    // SRAM: data for an address is visible two cycles after the address changes.
    logic [DW-1:0] mem [256];
    logic [AW-1:0] addr_d1;
    always @(posedge clk) addr_d1 <= sram_addr;
    assign dq = mem[addr_d1];

    int checks = 0, errors = 0;
    bit cur_dir = 1'b0;
    int mpos, mstart, mend, mlevel;
    bit mdir, mloop;

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int m_step(input int lvl);
        int s;
        if (lvl >= 0) return (lvl + 1) * FR;
        s = FR / (1 - lvl);
        if (s < 1) s = 1;
        return s;
    endfunction

    function automatic logic [DW-1:0] m_out();
        int a_addr, fr, a;
        a_addr = mpos / FR;
        fr     = mpos % FR;
        a      = int'($signed(mem[a_addr]));
`ifdef SRAM_PLAYER_INTERP_EN
        begin
            int b_addr, b, prod, q;
            if (mdir) b_addr = (a_addr <= mstart) ? mstart : a_addr - 1;
            else      b_addr = (a_addr >= mend) ? mend : a_addr + 1;
            b    = int'($signed(mem[b_addr]));
            prod = (b - a) * fr;
            q    = prod / FR;
            if (prod < 0 && (prod % FR) != 0) q = q - 1;
            a    = a + q;
        end
`else
        if (fr < 0) a = 0;
`endif
        return DW'(a);
    endfunction

    function automatic void m_advance(output bit dn_o);
        int np;
        bit past;
        np   = mdir ? mpos - m_step(mlevel) : mpos + m_step(mlevel);
        past = mdir ? (np < mstart * FR) : (np >= (mend + 1) * FR);
        dn_o = past && !mloop;
        if (past) mpos = mdir ? mend * FR : mstart * FR;
        else      mpos = np;
    endfunction

    task automatic go_stop();
        enable = 1'b0; step();
        enable = 1'b1; step(); step();
    endtask

    task automatic set_level(input int l);
        for (int i = 0; i < l; i++) begin up = 1'b1; step(); up = 1'b0; step(); end
        for (int i = 0; i < -l; i++) begin dn = 1'b1; step(); dn = 1'b0; step(); end
        mlevel = l;
        checks++;
        if (speed !== 4'(l)) begin errors++; $display("FAIL speed_level got %0d want %0d", $signed(speed), l); end
    endtask

    task automatic set_dir(input bit d);
        if (cur_dir != d) begin rev = 1'b1; step(); rev = 1'b0; step(); cur_dir = d; end
        checks++;
        if (dir !== cur_dir) begin errors++; $display("FAIL dir got %0b want %0b", dir, cur_dir); end
    endtask

    task automatic start_play(input int s, input int e, input bit lp);
        start_a = AW'(s); end_a = AW'(e); loop_l = lp;
        step();
        pp = 1'b1; step(); pp = 1'b0;
        mstart = s; mend = e; mloop = lp; mdir = cur_dir;
        mpos = mdir ? e * FR : s * FR;
        checks++;
        if (state !== 3'b100 || play_n !== 1'b0) begin
            errors++; $display("FAIL enter_play state %b play_n %b want 100/0", state, play_n);
        end
    endtask

    task automatic do_tick(input string nm, output bit got_done);
        logic [DW-1:0] exp_d;
        bit exp_done;
        int n;
        exp_d = m_out();
        m_advance(exp_done);
        tick = 1'b1; step(); tick = 1'b0;
        n = 0;
        while (!valid && n < 40) begin step(); n++; end
        checks++;
        if (!valid) begin
            errors++; $display("FAIL %s no o_valid within 40 cycles", nm);
        end else begin
            checks++;
            if (n != EXP_LAT) begin errors++; $display("FAIL %s latency got %0d want %0d", nm, n, EXP_LAT); end
            checks++;
            if (dacdat !== exp_d) begin errors++; $display("FAIL %s dacdat got %h want %h", nm, dacdat, exp_d); end
            checks++;
            if (done !== exp_done) begin errors++; $display("FAIL %s done got %b want %b", nm, done, exp_done); end
            if (exp_done) begin
                checks++;
                if (state !== 3'b011) begin errors++; $display("FAIL %s state_after_done got %b want 011", nm, state); end
            end
        end
        got_done = exp_done;
        step();
        checks++;
        if (valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s pulse_width valid %b done %b want 0/0", nm, valid, done); end
        step();
    endtask

    task automatic check_reset_vals(input string nm);
        checks++;
        if (state !== 3'b001 || play_n !== 1'b1 || valid !== 1'b0 || done !== 1'b0 || overrun !== 1'b0 ||
            dacdat !== '0 || sram_addr !== '0 || speed !== '0 || dir !== 1'b0) begin
            errors++;
            $display("FAIL %s state %b play_n %b valid %b done %b ovr %b dac %h addr %h spd %h dir %b want 001 1 0 0 0 0 0 0 0",
                     nm, state, play_n, valid, done, overrun, dacdat, sram_addr, speed, dir);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; step(); step();
        check_reset_vals("reset_held");
        rst_n = 1'b1; step(); step();
        check_reset_vals("reset_released_disabled");
    endtask

    task automatic test_forward();
        bit d;
        go_stop(); set_level(0); set_dir(1'b0);
        checks++;
        if (state !== 3'b011) begin errors++; $display("FAIL idle_to_stop got %b want 011", state); end
        start_play(100, 103, 1'b0);
        for (int i = 0; i < 4; i++) do_tick("forward", d);
        checks++;
        if (d !== 1'b1) begin errors++; $display("FAIL forward_end got done %b want 1", d); end
    endtask

    task automatic test_slow();
        bit d;
        mem[100] = 16'h0100; mem[101] = 16'h0200;
        go_stop(); set_level(-1); set_dir(1'b0);
        start_play(100, 103, 1'b0);
        for (int i = 0; i < 3; i++) do_tick("slow", d);
    endtask

    task automatic test_fast_sat();
        bit d;
        go_stop(); set_level(3); set_dir(1'b0);
        start_play(100, 115, 1'b0);
        for (int i = 0; i < 3; i++) do_tick("fast", d);
        stp = 1'b1; step(); stp = 1'b0; step();
        for (int i = 0; i < 10; i++) begin up = 1'b1; step(); up = 1'b0; step(); end
        checks++;
        if (speed !== 4'd7) begin errors++; $display("FAIL speed_sat_hi got %0d want 7", $signed(speed)); end
        up = 1'b1; dn = 1'b1; step(); up = 1'b0; dn = 1'b0; step();
        checks++;
        if (speed !== 4'd7) begin errors++; $display("FAIL speed_up_down_same got %0d want 7", $signed(speed)); end
        for (int i = 0; i < 20; i++) begin dn = 1'b1; step(); dn = 1'b0; step(); end
        checks++;
        if (speed !== 4'b1001) begin errors++; $display("FAIL speed_sat_lo got %0d want -7", $signed(speed)); end
    endtask

    task automatic test_reverse_loop();
        bit d;
        go_stop(); set_level(0); set_dir(1'b1);
        start_play(10, 12, 1'b1);
        for (int i = 0; i < 5; i++) do_tick("reverse_loop", d);
    endtask

    task automatic test_boundaries();
        bit d;
        go_stop(); set_level(7); set_dir(1'b0);
        start_play(250, 255, 1'b0);
        do_tick("fwd_overflow", d);
        go_stop(); set_level(7); set_dir(1'b1);
        start_play(0, 3, 1'b0);
        do_tick("rev_underflow", d);
        go_stop(); set_level(-7); set_dir(1'b1);
        start_play(0, 1, 1'b1);
        for (int i = 0; i < 10; i++) do_tick("rev_slow_wrap", d);
    endtask

    task automatic test_random();
        bit d;
        int lvl, s, e;
        for (int r = 0; r < 8; r++) begin
            lvl = int'($urandom_range(0, 14)) - 7;
            s   = int'($urandom_range(0, 200));
            e   = s + int'($urandom_range(0, 6));
            go_stop(); set_level(lvl); set_dir(bit'($urandom_range(0, 1)));
            start_play(s, e, bit'($urandom_range(0, 1)));
            for (int i = 0; i < 10; i++) begin
                do_tick("random", d);
                if (d) break;
            end
        end
    endtask

    task automatic test_overrun_abort();
        bit d;
        int nvalid;
        go_stop(); set_level(0); set_dir(1'b0);
        start_play(20, 60, 1'b0);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_initial got %b want 0", overrun); end
        for (int i = 0; i < 6; i++) begin tick = 1'b1; step(); tick = 1'b0; step(); end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", overrun); end
        stp = 1'b1; step(); stp = 1'b0;
        checks++;
        if (overrun !== 1'b0 || state !== 3'b011) begin
            errors++; $display("FAIL stop_clears overrun %b state %b want 0/011", overrun, state);
        end
        start_play(20, 60, 1'b0);
        do_tick("restart_from_start", d);
        tick = 1'b1; step(); tick = 1'b0; step();
        pp = 1'b1; step(); pp = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 12; i++) begin if (valid) nvalid++; step(); end
        checks++;
        if (nvalid != 0) begin errors++; $display("FAIL pause_abort valid pulses got %0d want 0", nvalid); end
        checks++;
        if (state !== 3'b101 || play_n !== 1'b1) begin
            errors++; $display("FAIL pause_state got %b play_n %b want 101/1", state, play_n);
        end
        pp = 1'b1; step(); pp = 1'b0;
        do_tick("resume_after_abort", d);
    endtask

    task automatic test_reset_mid_fetch();
        bit d;
        go_stop(); set_level(2); set_dir(1'b1);
        start_play(30, 40, 1'b0);
        do_tick("pre_reset", d);
        tick = 1'b1; step(); tick = 1'b0; step();
        rst_n = 1'b0; #1;
        check_reset_vals("async_reset_mid_fetch");
        step();
        rst_n = 1'b1; cur_dir = 1'b0;
        step();
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 16'($urandom);
        test_reset();
        test_forward();
        test_slow();
        test_fast_sat();
        test_reverse_loop();
        test_boundaries();
        test_random();
        test_overrun_abort();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
